// File: rtl/traffic_pkg.sv
// Shared definitions for the multi-approach traffic controller: lamp
// encodings, the controller state enum and the phase-length lookup.
// The VIP states are always present in the enum; they are only reachable
// when TRAFFIC_VIP_EN is defined.
package traffic_pkg;

    // Car head encodings, one-hot-ish lamp drive {red, yellow, arrow, green}
    localparam logic [3:0] CAR_RED    = 4'b1000;
    localparam logic [3:0] CAR_YELLOW = 4'b0100;
    localparam logic [3:0] CAR_LEFT   = 4'b1010;
    localparam logic [3:0] CAR_GREEN  = 4'b0001;

    // Pedestrian head encodings {red, green}
    localparam logic [1:0] WALK_RED   = 2'b10;
    localparam logic [1:0] WALK_GREEN = 2'b01;
    localparam logic [1:0] WALK_OFF   = 2'b00;

    typedef enum logic [3:0] {
        S_GREEN,
        S_YEL1,
        S_LEFT,
        S_YEL2,
        S_CLEAR,
        S_VIP_YEL,
        S_VIP_CLEAR,
        S_VIP_GREEN,
        S_VIP_XYEL,
        S_VIP_XCLR
    } fsm_e;

    // Length in cycles of the phase a state represents. S_VIP_GREEN has no
    // timeout; it returns 1 only so the result is always defined.
    function automatic int unsigned phase_len(
        input fsm_e        st,
        input int unsigned green_t,
        input int unsigned yel_t,
        input int unsigned left_t,
        input int unsigned clr_t
    );
        int unsigned len;
        case (st)
            S_GREEN:                                len = green_t;
            S_YEL1, S_YEL2, S_VIP_YEL, S_VIP_XYEL:  len = yel_t;
            S_LEFT:                                 len = left_t;
            S_CLEAR, S_VIP_CLEAR, S_VIP_XCLR:       len = clr_t;
            default:                                len = 1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/traffic_ctrl_multi_decode.sv
// Per-approach lamp decoder: turns the controller state, the owning
// approach and the blink bit into one approach's car and walk heads.
module traffic_path_decode
    import traffic_pkg::*;
#(
    parameter int PW = 2
) (
    input  fsm_e          fsm_i,
    input  logic [PW-1:0] serve_path_i,
    input  logic          cnt0_i,
    input  logic [PW-1:0] idx_i,
    output logic [3:0]    car_o,
    output logic [1:0]    walk_o
);

    logic own;

    assign own = (serve_path_i == idx_i);

    // Car head: only the owning approach ever shows anything but red;
    // walk head: crossing pedestrians move while their car head is red,
    // blink during the second yellow, and stop for clearance and VIP.
    always_comb begin
        car_o  = CAR_RED;
        walk_o = WALK_RED;
        case (fsm_i)
            S_GREEN, S_VIP_GREEN:                   if (own) car_o = CAR_GREEN;
            S_YEL1, S_YEL2, S_VIP_YEL, S_VIP_XYEL:  if (own) car_o = CAR_YELLOW;
            S_LEFT:                                 if (own) car_o = CAR_LEFT;
            default:                                car_o = CAR_RED;
        endcase
        case (fsm_i)
            S_GREEN, S_YEL1, S_LEFT: walk_o = own ? WALK_RED : WALK_GREEN;
            S_YEL2:                  walk_o = own ? WALK_RED : (cnt0_i ? WALK_OFF : WALK_GREEN);
            default:                 walk_o = WALK_RED;
        endcase
    end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// N-approach round-robin intersection controller. Each approach gets
// GREEN, YELLOW, LEFT, YELLOW then an all-red clearance before the next
// approach is served. Define TRAFFIC_VIP_EN to build emergency-vehicle
// preemption (vip_req/vip_path); without it those inputs are ignored and
// vip_active stays low.
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter  int N_PATH  = 4,
    parameter  int GREEN_T = 20,
    parameter  int YEL_T   = 3,
    parameter  int LEFT_T  = 10,
    parameter  int CLR_T   = 2,
    parameter  int CNT_W   = 7,
    localparam int PW      = $clog2(N_PATH)
) (
    input  logic                clk,
    input  logic                start,
    input  logic                vip_req,
    input  logic [PW-1:0]       vip_path,
    output logic [4*N_PATH-1:0] car_traffic,
    output logic [2*N_PATH-1:0] walk_traffic,
    output logic [PW-1:0]       serve_path,
    output logic                vip_active
);

    fsm_e             fsm_q, fsm_d;
    logic [PW-1:0]    serve_q, serve_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_end;

`ifdef TRAFFIC_VIP_EN
    logic [PW-1:0]    vip_lat_q, vip_lat_d;
    logic [PW-1:0]    resume_q, resume_d;
    logic [CNT_W-1:0] cnt_keep;
    logic             is_normal;
`else
    logic             unused_vip;
    assign unused_vip = ^{vip_req, vip_path};
`endif

    function automatic logic [PW-1:0] next_path(input logic [PW-1:0] p);
        return (p == PW'(N_PATH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign phase_end = (32'(cnt_q) ==
                        phase_len(fsm_q, GREEN_T, YEL_T, LEFT_T, CLR_T) - 32'd1);

    // State register; start low clears everything without waiting for clk
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            fsm_q     <= S_GREEN;
            serve_q   <= '0;
            cnt_q     <= '0;
`ifdef TRAFFIC_VIP_EN
            vip_lat_q <= '0;
            resume_q  <= '0;
`endif
        end else begin
            fsm_q     <= fsm_d;
            serve_q   <= serve_d;
            cnt_q     <= cnt_d;
`ifdef TRAFFIC_VIP_EN
            vip_lat_q <= vip_lat_d;
            resume_q  <= resume_d;
`endif
        end
    end

    // Next state: phase sequencing, then VIP entry overriding normal states
    always_comb begin
        fsm_d   = fsm_q;
        serve_d = serve_q;
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef TRAFFIC_VIP_EN
        vip_lat_d = vip_lat_q;
        resume_d  = resume_q;
        // Entering a hand-over mid-phase continues the running timer; if the
        // phase was already on its last cycle the timer holds there so the
        // hand-over state still terminates on its next edge.
        cnt_keep  = phase_end ? cnt_q : cnt_q + CNT_W'(1);
        is_normal = (fsm_q == S_GREEN) || (fsm_q == S_YEL1) || (fsm_q == S_LEFT) ||
                    (fsm_q == S_YEL2) || (fsm_q == S_CLEAR);
`endif
        case (fsm_q)
            S_GREEN: if (phase_end) begin fsm_d = S_YEL1;  cnt_d = '0; end
            S_YEL1:  if (phase_end) begin fsm_d = S_LEFT;  cnt_d = '0; end
            S_LEFT:  if (phase_end) begin fsm_d = S_YEL2;  cnt_d = '0; end
            S_YEL2:  if (phase_end) begin fsm_d = S_CLEAR; cnt_d = '0; end
            S_CLEAR: if (phase_end) begin
                fsm_d   = S_GREEN;
                serve_d = next_path(serve_q);
                cnt_d   = '0;
            end
`ifdef TRAFFIC_VIP_EN
            S_VIP_YEL: if (phase_end) begin fsm_d = S_VIP_CLEAR; cnt_d = '0; end
            S_VIP_CLEAR: if (phase_end) begin
                cnt_d = '0;
                if (vip_req) begin
                    fsm_d   = S_VIP_GREEN;
                    serve_d = vip_lat_q;
                end else begin
                    fsm_d   = S_GREEN;
                    serve_d = resume_q;
                end
            end
            S_VIP_GREEN: begin
                cnt_d = '0;
                if (!vip_req) fsm_d = S_VIP_XYEL;
            end
            S_VIP_XYEL: if (phase_end) begin fsm_d = S_VIP_XCLR; cnt_d = '0; end
            S_VIP_XCLR: if (phase_end) begin
                fsm_d   = S_GREEN;
                serve_d = resume_q;
                cnt_d   = '0;
            end
`endif
            default: begin
                fsm_d   = S_GREEN;
                serve_d = '0;
                cnt_d   = '0;
            end
        endcase
`ifdef TRAFFIC_VIP_EN
        if (vip_req && is_normal) begin
            vip_lat_d = vip_path;
            case (fsm_q)
                S_GREEN: begin
                    cnt_d = '0;
                    if (serve_q == vip_path) begin
                        fsm_d    = S_VIP_GREEN;
                        resume_d = next_path(serve_q);
                    end else begin
                        fsm_d    = S_VIP_YEL;
                        resume_d = serve_q;
                    end
                    serve_d = serve_q;
                end
                S_YEL1: begin
                    fsm_d = S_VIP_YEL;  cnt_d = cnt_keep; serve_d = serve_q;
                    resume_d = serve_q;
                end
                S_LEFT: begin
                    fsm_d = S_VIP_YEL;  cnt_d = '0;       serve_d = serve_q;
                    resume_d = next_path(serve_q);
                end
                S_YEL2: begin
                    fsm_d = S_VIP_YEL;  cnt_d = cnt_keep; serve_d = serve_q;
                    resume_d = next_path(serve_q);
                end
                default: begin
                    fsm_d = S_VIP_CLEAR; cnt_d = cnt_keep; serve_d = serve_q;
                    resume_d = next_path(serve_q);
                end
            endcase
        end
`endif
    end

    // Outputs: owning approach and VIP flag decoded from registers
    always_comb begin
        serve_path = serve_q;
        vip_active = 1'b0;
`ifdef TRAFFIC_VIP_EN
        vip_active = (fsm_q == S_VIP_YEL) || (fsm_q == S_VIP_CLEAR) ||
                     (fsm_q == S_VIP_GREEN) || (fsm_q == S_VIP_XYEL) ||
                     (fsm_q == S_VIP_XCLR);
`endif
    end

    for (genvar gi = 0; gi < N_PATH; gi++) begin : g_path
        traffic_path_decode #(.PW(PW)) u_dec (
            .fsm_i        (fsm_q),
            .serve_path_i (serve_q),
            .cnt0_i       (cnt_q[0]),
            .idx_i        (PW'(gi)),
            .car_o        (car_traffic[4*gi +: 4]),
            .walk_o       (walk_traffic[2*gi +: 2])
        );
    end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi at default parameters. Expected lamps come
// from a cycle-index model of the round-robin schedule plus a fixed table;
// VIP sequences are exercised when TRAFFIC_VIP_EN is defined.
module tb_traffic_ctrl_multi;
  localparam int N   = 4;
  localparam int GT  = 20;
  localparam int YT  = 3;
  localparam int LT  = 10;
  localparam int CT  = 2;
  localparam int PER = GT + 2*YT + LT + CT;

  localparam logic [3:0] C_RED = 4'b1000;
  localparam logic [3:0] C_YEL = 4'b0100;
  localparam logic [3:0] C_LFT = 4'b1010;
  localparam logic [3:0] C_GRN = 4'b0001;

  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic        vip_req = 1'b0;
  logic [1:0]  vip_path = 2'd0;
  logic [15:0] car;
  logic [7:0]  walk;
  logic [1:0]  serve;
  logic        vact;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic [15:0] car;
    logic [7:0]  walk;
    logic [1:0]  serve;
  } vec_t;
  vec_t vec [13];

  traffic_ctrl_multi dut (
    .clk          (clk),
    .start        (start),
    .vip_req      (vip_req),
    .vip_path     (vip_path),
    .car_traffic  (car),
    .walk_traffic (walk),
    .serve_path   (serve),
    .vip_active   (vact)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [15:0] car_vec(input int sp, input logic [3:0] head);
    logic [15:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = (i == sp) ? head : C_RED;
    return v;
  endfunction

  // mode 0: crossing walks green, 1: crossing walks off, 2: all red
  function automatic logic [7:0] walk_vec(input int sp, input int mode);
    logic [7:0] v;
    for (int i = 0; i < N; i++)
      v[2*i +: 2] = (mode == 2 || i == sp) ? 2'b10 : ((mode == 1) ? 2'b00 : 2'b01);
    return v;
  endfunction

  // Schedule model: k cycles after a cycle started at approach base
  task automatic model(input int k, input int base,
                       output logic [15:0] ec, output logic [7:0] ew, output logic [1:0] es);
    int ap;
    int ph;
    ap = (base + k / PER) % N;
    ph = k % PER;
    es = 2'(ap);
    if (ph < GT) begin
      ec = car_vec(ap, C_GRN); ew = walk_vec(ap, 0);
    end else if (ph < GT + YT) begin
      ec = car_vec(ap, C_YEL); ew = walk_vec(ap, 0);
    end else if (ph < GT + YT + LT) begin
      ec = car_vec(ap, C_LFT); ew = walk_vec(ap, 0);
    end else if (ph < GT + 2*YT + LT) begin
      ec = car_vec(ap, C_YEL);
      ew = walk_vec(ap, ((ph - (GT + YT + LT)) % 2 == 1) ? 1 : 0);
    end else begin
      ec = car_vec(-1, C_RED); ew = walk_vec(ap, 2);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] ec, input logic [7:0] ew,
                           input logic [1:0] es, input logic ev);
    check({tag, ".car"}, 32'(car), 32'(ec));
    check({tag, ".walk"}, 32'(walk), 32'(ew));
    check({tag, ".serve"}, 32'(serve), 32'(es));
    check({tag, ".vip"}, 32'(vact), 32'(ev));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called 1 time unit after a rising edge; reset is checked before the next edge
  task automatic do_reset();
    start = 1'b0;
    #1;
    check_out("reset", 16'h8881, 8'h56, 2'd0, 1'b0);
    vip_req = 1'b0;
    #1;
    start = 1'b1;
    cyc = 0;
  endtask

  // Check n cycles of the normal schedule from index k0, advancing each time
  task automatic run_norm(input int base, input int k0, input int n);
    logic [15:0] ec;
    logic [7:0]  ew;
    logic [1:0]  es;
    for (int k = k0; k < k0 + n; k++) begin
      model(k, base, ec, ew, es);
      check_out("norm", ec, ew, es, 1'b0);
      next_cycle();
    end
  endtask

  task automatic expect_n(input string tag, input int n, input logic [15:0] ec,
                          input logic [7:0] ew, input logic [1:0] es, input logic ev);
    for (int k = 0; k < n; k++) begin
      check_out(tag, ec, ew, es, ev);
      next_cycle();
    end
  endtask

  initial begin
    logic [15:0] ec;
    logic [7:0]  ew;
    logic [1:0]  es;

    vec[0]  = '{0,   16'h8881, 8'h56, 2'd0};
    vec[1]  = '{19,  16'h8881, 8'h56, 2'd0};
    vec[2]  = '{20,  16'h8884, 8'h56, 2'd0};
    vec[3]  = '{22,  16'h8884, 8'h56, 2'd0};
    vec[4]  = '{23,  16'h888A, 8'h56, 2'd0};
    vec[5]  = '{32,  16'h888A, 8'h56, 2'd0};
    vec[6]  = '{33,  16'h8884, 8'h56, 2'd0};
    vec[7]  = '{34,  16'h8884, 8'h02, 2'd0};
    vec[8]  = '{35,  16'h8884, 8'h56, 2'd0};
    vec[9]  = '{36,  16'h8888, 8'hAA, 2'd0};
    vec[10] = '{37,  16'h8888, 8'hAA, 2'd0};
    vec[11] = '{38,  16'h8818, 8'h59, 2'd1};
    vec[12] = '{152, 16'h8881, 8'h56, 2'd0};

    @(posedge clk);
    #1;
    do_reset();

    // Plain schedule against the model and the fixed table
    for (int t = 0; t <= 160; t++) begin
      model(t, 0, ec, ew, es);
      check_out("sched", ec, ew, es, 1'b0);
      for (int j = 0; j < 13; j++) begin
        if (vec[j].c == t) begin
          check("vec.car", 32'(car), 32'(vec[j].car));
          check("vec.walk", 32'(walk), 32'(vec[j].walk));
          check("vec.serve", 32'(serve), 32'(vec[j].serve));
        end
      end
      next_cycle();
    end

    // Random inputs: requests only matter when preemption is built
    do_reset();
    for (int t = 0; t <= 250; t++) begin
      model(t, 0, ec, ew, es);
      check_out("rand", ec, ew, es, 1'b0);
`ifdef TRAFFIC_VIP_EN
      vip_req = 1'b0;
`else
      vip_req = 1'($urandom_range(0, 1));
`endif
      vip_path = 2'($urandom_range(0, 3));
      if (t < 250) next_cycle();
    end
    // Mid-run reset (approach 2 in yellow) must take effect without a clock
    do_reset();
    vip_path = 2'd0;
    run_norm(0, 0, 40);

`ifdef TRAFFIC_VIP_EN
    // Request approach 2 while approach 0 is green
    do_reset();
    run_norm(0, 0, 4);
    vip_req = 1'b1; vip_path = 2'd2;
    run_norm(0, 4, 1);
    expect_n("vyel", 1, car_vec(0, C_YEL), walk_vec(0, 2), 2'd0, 1'b1);
    vip_path = 2'd1;
    expect_n("vyel", 2, car_vec(0, C_YEL), walk_vec(0, 2), 2'd0, 1'b1);
    expect_n("vclr", 2, car_vec(-1, C_RED), walk_vec(0, 2), 2'd0, 1'b1);
    expect_n("vgrn", 9, car_vec(2, C_GRN), walk_vec(2, 2), 2'd2, 1'b1);
    vip_req = 1'b0;
    expect_n("vgrn", 1, car_vec(2, C_GRN), walk_vec(2, 2), 2'd2, 1'b1);
    expect_n("xyel", 1, car_vec(2, C_YEL), walk_vec(2, 2), 2'd2, 1'b1);
    vip_req = 1'b1;
    expect_n("xyel", 1, car_vec(2, C_YEL), walk_vec(2, 2), 2'd2, 1'b1);
    vip_req = 1'b0;
    expect_n("xyel", 1, car_vec(2, C_YEL), walk_vec(2, 2), 2'd2, 1'b1);
    expect_n("xclr", 2, car_vec(-1, C_RED), walk_vec(2, 2), 2'd2, 1'b1);
    run_norm(0, 0, 40);

    // Request the approach already green: held indefinitely
    do_reset();
    run_norm(0, 0, 2);
    vip_req = 1'b1; vip_path = 2'd0;
    run_norm(0, 2, 1);
    expect_n("hold", 44, car_vec(0, C_GRN), walk_vec(0, 2), 2'd0, 1'b1);
    vip_req = 1'b0;
    expect_n("hold", 1, car_vec(0, C_GRN), walk_vec(0, 2), 2'd0, 1'b1);
    expect_n("xyel", 3, car_vec(0, C_YEL), walk_vec(0, 2), 2'd0, 1'b1);
    expect_n("xclr", 2, car_vec(-1, C_RED), walk_vec(0, 2), 2'd0, 1'b1);
    run_norm(1, 0, 40);

    // Request during the first clearance cycle of approach 1
    do_reset();
    run_norm(0, 0, 74);
    vip_req = 1'b1; vip_path = 2'd3;
    run_norm(0, 74, 1);
    expect_n("cclr", 1, car_vec(-1, C_RED), walk_vec(1, 2), 2'd1, 1'b1);
    expect_n("cgrn", 4, car_vec(3, C_GRN), walk_vec(3, 2), 2'd3, 1'b1);
    vip_req = 1'b0;
    expect_n("cgrn", 1, car_vec(3, C_GRN), walk_vec(3, 2), 2'd3, 1'b1);
    expect_n("xyel", 3, car_vec(3, C_YEL), walk_vec(3, 2), 2'd3, 1'b1);
    expect_n("xclr", 2, car_vec(-1, C_RED), walk_vec(3, 2), 2'd3, 1'b1);
    run_norm(2, 0, 40);

    // Reset while a VIP approach is green
    do_reset();
    run_norm(0, 0, 2);
    vip_req = 1'b1; vip_path = 2'd1;
    run_norm(0, 2, 1);
    expect_n("dyel", 3, car_vec(0, C_YEL), walk_vec(0, 2), 2'd0, 1'b1);
    expect_n("dclr", 2, car_vec(-1, C_RED), walk_vec(0, 2), 2'd0, 1'b1);
    expect_n("dgrn", 3, car_vec(1, C_GRN), walk_vec(1, 2), 2'd1, 1'b1);
    do_reset();
    run_norm(0, 0, 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
